// File: rtl/cuenta_tiempo_pkg.sv
// Shared definitions for the cuenta_tiempo clock block.
// Holds the BCD wrap limits for every field, the set_sel field encodings
// and a helper that advances a 2-digit BCD value by one.
// The 12 h limits are used only when CUENTA_TIEMPO_HR12_EN is defined.
package cuenta_tiempo_pkg;

  localparam logic [7:0] CS_MAX        = 8'h99;
  localparam logic [7:0] SEG_MAX       = 8'h59;
  localparam logic [7:0] HR24_MAX      = 8'h23;
  localparam logic [7:0] HR12_MAX      = 8'h12;
  localparam logic [7:0] HR12_MIN      = 8'h01;
  // Hour value just before noon/midnight; stepping past it flips AM/PM.
  localparam logic [7:0] HR12_PRE_NOON = 8'h11;

  // Field selected while in time-set mode; the last two codes select nothing.
  typedef enum logic [1:0] {
    SEL_MIN    = 2'b00,
    SEL_HR     = 2'b01,
    SEL_NONE_A = 2'b10,
    SEL_NONE_B = 2'b11
  } set_sel_e;

  // Add one to a 2-digit BCD value, rippling the units carry into the tens.
  // Wrapping at the field limit is the caller's job.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/cuenta_tiempo_cnt_bcd2.sv
// cnt_bcd2: 2-digit BCD counter used for every time field.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset, loads RST_VAL
//   en_i    - advance by one; at MAX_VAL the counter reloads MIN_VAL
//   clr_i   - synchronous clear to RST_VAL, has priority over en_i
//   val_o   - registered BCD value
//   carry_o - combinational: this cycle's advance wraps the counter
module cnt_bcd2
  import cuenta_tiempo_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = 8'h99,
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [7:0] val_o,
  output logic       carry_o
);

  logic [7:0] val_q, val_d;

  // Next value: clear wins, otherwise wrap at the limit or step in BCD.
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = RST_VAL;
    end else if (en_i) begin
      val_d = (val_q == MAX_VAL) ? MIN_VAL : bcd_inc(val_q);
    end
  end

  // Value register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  // The carry is combinational so a whole chain of fields can roll over
  // on the same clock edge.
  assign carry_o = en_i & ~clr_i & (val_q == MAX_VAL);
  assign val_o   = val_q;

endmodule

// File: rtl/cuenta_tiempo.sv
// cuenta_tiempo: time-of-day counter (HH:MM:SS.CC) in BCD, driven by an
// asynchronous 100 Hz reference, with a set mode for minutes and hours.
// Ports:
//   clk        - master clock
//   rst        - asynchronous active-low reset
//   f100       - 100 Hz square wave, asynchronous to clk
//   set_mode   - 1 = set time, 0 = run
//   set_sel    - field to set: 00 minutes, 01 hours, others nothing
//   inc        - debounced increment button, asynchronous to clk
//   cs_bcd     - centiseconds 00..99
//   seg_bcd    - seconds 00..59
//   min_bcd    - minutes 00..59
//   hr_bcd     - hours 00..23, or 12,01..11 in 12 h build
//   pm         - 1 = PM (only with CUENTA_TIEMPO_HR12_EN)
//   seg_pulse  - one-clock strobe on each seconds increment
// Build option: define CUENTA_TIEMPO_HR12_EN for the 12 h clock with pm.
module cuenta_tiempo
  import cuenta_tiempo_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f100,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       inc,
  output logic [7:0] cs_bcd,
  output logic [7:0] seg_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
`ifdef CUENTA_TIEMPO_HR12_EN
  output logic       pm,
`endif
  output logic       seg_pulse
);

`ifdef CUENTA_TIEMPO_HR12_EN
  localparam logic [7:0] HR_MAX = HR12_MAX;
  localparam logic [7:0] HR_MIN = HR12_MIN;
  localparam logic [7:0] HR_RST = HR12_MAX;
`else
  localparam logic [7:0] HR_MAX = HR24_MAX;
  localparam logic [7:0] HR_MIN = 8'h00;
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  logic [SYNC_STAGES-1:0] fSync_q, incSync_q;
  logic [SYNC_STAGES:0]   syncVld_q;
  logic fPrev_q, incPrev_q, tick_q, incP_q, segPulse_q;
  logic fLvl, incLvl;
  logic csEn, segEn, minEn, hrEn, setMin, setHr;
  logic csCarry, segCarry, minCarry, unused_hr_carry;
  logic [7:0] csVal, segVal, minVal, hrVal;

  assign fLvl   = fSync_q[SYNC_STAGES-1];
  assign incLvl = incSync_q[SYNC_STAGES-1];

  // Synchronizers and rising-edge detectors for f100 and inc. syncVld_q
  // fills with ones after reset so that edges are only reported once the
  // previous-level flop holds a real synchronized sample; a level that was
  // already high at reset release therefore never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fSync_q   <= '0;
      incSync_q <= '0;
      syncVld_q <= '0;
      fPrev_q   <= 1'b0;
      incPrev_q <= 1'b0;
      tick_q    <= 1'b0;
      incP_q    <= 1'b0;
    end else begin
      fSync_q   <= {fSync_q[SYNC_STAGES-2:0], f100};
      incSync_q <= {incSync_q[SYNC_STAGES-2:0], inc};
      syncVld_q <= {syncVld_q[SYNC_STAGES-1:0], 1'b1};
      fPrev_q   <= fLvl;
      incPrev_q <= incLvl;
      tick_q    <= fLvl & ~fPrev_q & syncVld_q[SYNC_STAGES];
      incP_q    <= incLvl & ~incPrev_q & syncVld_q[SYNC_STAGES];
    end
  end

  // Ticks only count in run mode, so a tick landing on the cycle set_mode
  // rises is dropped. In set mode the button steps one field and its wrap
  // carry is masked off from the hours.
  assign setMin = set_mode & incP_q & (set_sel == SEL_MIN);
  assign setHr  = set_mode & incP_q & (set_sel == SEL_HR);
  assign csEn   = ~set_mode & tick_q;
  assign segEn  = csCarry;
  assign minEn  = segCarry | setMin;
  assign hrEn   = (~set_mode & minCarry) | setHr;

  cnt_bcd2 #(.MAX_VAL(CS_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) uCs (
    .clk_i(clk), .rst_ni(rst), .en_i(csEn), .clr_i(set_mode),
    .val_o(csVal), .carry_o(csCarry)
  );

  cnt_bcd2 #(.MAX_VAL(SEG_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) uSeg (
    .clk_i(clk), .rst_ni(rst), .en_i(segEn), .clr_i(set_mode),
    .val_o(segVal), .carry_o(segCarry)
  );

  cnt_bcd2 #(.MAX_VAL(SEG_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) uMin (
    .clk_i(clk), .rst_ni(rst), .en_i(minEn), .clr_i(1'b0),
    .val_o(minVal), .carry_o(minCarry)
  );

  cnt_bcd2 #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) uHr (
    .clk_i(clk), .rst_ni(rst), .en_i(hrEn), .clr_i(1'b0),
    .val_o(hrVal), .carry_o(unused_hr_carry)
  );

  // Seconds strobe, registered alongside the seconds counter so it is high
  // in exactly the cycle the new seconds value appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      segPulse_q <= 1'b0;
    end else begin
      segPulse_q <= segEn;
    end
  end

`ifdef CUENTA_TIEMPO_HR12_EN
  logic pm_q, pm_d;

  // AM/PM flips whenever the hours step from 11 to 12, in either mode.
  always_comb begin
    pm_d = pm_q;
    if (hrEn && (hrVal == HR12_PRE_NOON)) begin
      pm_d = ~pm_q;
    end
  end

  // AM/PM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`endif

  assign cs_bcd    = csVal;
  assign seg_bcd   = segVal;
  assign min_bcd   = minVal;
  assign hr_bcd    = hrVal;
  assign seg_pulse = segPulse_q;

endmodule

// File: tb/tb_cuenta_tiempo.sv
// Testbench for cuenta_tiempo. A time-of-day model (plain integers) follows
// the inputs the bench drives, using the synchronizer latency as a fixed
// delay, and is compared with the DUT on every falling clock edge. Directed
// scenarios add literal checks at key points.
module tb_cuenta_tiempo;

  localparam int SYNC = 2;
`ifdef CUENTA_TIEMPO_HR12_EN
  localparam bit HR12 = 1'b1;
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam bit HR12 = 1'b0;
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  logic clk = 1'b0, rst = 1'b0, f100 = 1'b0, setMode = 1'b0, inc = 1'b0;
  logic [1:0] setSel = 2'b00;
  logic [7:0] csBcd, segBcd, minBcd, hrBcd;
  logic segPulse, pmOut;
  int total = 0, bad = 0, pulseCnt = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  cuenta_tiempo #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .f100(f100), .set_mode(setMode), .set_sel(setSel),
    .inc(inc), .cs_bcd(csBcd), .seg_bcd(segBcd), .min_bcd(minBcd),
    .hr_bcd(hrBcd),
`ifdef CUENTA_TIEMPO_HR12_EN
    .pm(pmOut),
`endif
    .seg_pulse(segPulse)
  );
`ifndef CUENTA_TIEMPO_HR12_EN
  assign pmOut = 1'b0;
`endif

  // Time-of-day model.
  int mCs = 0, mSec = 0, mMin = 0, mHr = HR12 ? 12 : 0;
  bit mPm = 1'b0, mPulse = 1'b0;
  int nEdge = 0;
  bit fHist[$];
  bit iHist[$];

  task automatic bumpHour();
    if (HR12) begin
      if (mHr == 11) mPm = ~mPm;
      mHr = (mHr == 12) ? 1 : mHr + 1;
    end else begin
      mHr = (mHr + 1) % 24;
    end
  endtask

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Input levels are recorded at each clock edge since reset; a rise seen
  // between samples k-1 and k takes effect at edge k+SYNC+1, and only when
  // both samples were taken after reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mCs = 0; mSec = 0; mMin = 0; mHr = HR12 ? 12 : 0;
      mPm = 1'b0; mPulse = 1'b0; nEdge = 0;
      fHist.delete(); iHist.delete();
    end else begin
      bit tickNow, incNow;
      tickNow = 1'b0;
      incNow  = 1'b0;
      nEdge++;
      if (nEdge - 3 - SYNC >= 0) begin
        tickNow = fHist[nEdge-2-SYNC] && !fHist[nEdge-3-SYNC];
        incNow  = iHist[nEdge-2-SYNC] && !iHist[nEdge-3-SYNC];
      end
      fHist.push_back(f100);
      iHist.push_back(inc);
      mPulse = 1'b0;
      if (setMode) begin
        mCs = 0;
        mSec = 0;
        if (incNow && setSel == 2'b00) mMin = (mMin + 1) % 60;
        else if (incNow && setSel == 2'b01) bumpHour();
      end else if (tickNow) begin
        mCs++;
        if (mCs == 100) begin
          mCs = 0; mPulse = 1'b1; mSec++;
          if (mSec == 60) begin
            mSec = 0; mMin++;
            if (mMin == 60) begin
              mMin = 0;
              bumpHour();
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [33:0] act, expv;
      act  = {csBcd, segBcd, minBcd, hrBcd, segPulse, pmOut};
      expv = {toBcd(mCs), toBcd(mSec), toBcd(mMin), toBcd(mHr), mPulse, mPm};
      total++;
      if (act !== expv) begin
        bad++;
        $display("[TB] FAIL model t=%0t got %h expected %h", $time, act, expv);
      end
      if (segPulse) pulseCnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // n pulses of 'half' cycles high / 'half' low on f100 or inc, then settle.
  task automatic applyStimulus(input bit isInc, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (isInc) inc = 1'b1; else f100 = 1'b1;
      repeat (half) @(negedge clk);
      if (isInc) inc = 1'b0; else f100 = 1'b0;
      repeat (half - 1) @(negedge clk);
    end
    repeat (SYNC + 4) @(negedge clk);
  endtask

  initial begin
    $display("[TB] start, HR12=%0d", HR12);
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetState", {csBcd, segBcd, minBcd, hrBcd}, {24'h0, HR_RST});
    checkOutput("resetPulse", {31'b0, segPulse}, 32'h0);

    // f100 already high when reset lifts must not tick.
    f100 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("staleF100", {csBcd, segBcd, minBcd, hrBcd}, {24'h0, HR_RST});
    f100 = 1'b0;
    repeat (4) @(negedge clk);

    // 100 ticks make one second.
    @(posedge clk); pulseCnt = 0;
    applyStimulus(1'b0, 100, 2);
    checkOutput("oneSecond", {csBcd, segBcd, minBcd}, 32'h000100);
    checkOutput("oneSecondPulses", pulseCnt, 1);

    // Hours set: 25 presses from the reset hour land on 01 in both builds.
    setMode = 1'b1; setSel = 2'b01;
    applyStimulus(1'b1, 25, 2);
    checkOutput("setHours", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000001);
`ifdef CUENTA_TIEMPO_HR12_EN
    checkOutput("setHoursPm", {31'b0, pmOut}, 32'h0);
`endif

    // Unused selector and run-mode presses change nothing.
    setSel = 2'b11;
    applyStimulus(1'b1, 5, 2);
    checkOutput("selNone", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000001);
    setMode = 1'b0; setSel = 2'b00;
    applyStimulus(1'b1, 3, 2);
    checkOutput("incRunMode", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000001);

`ifndef CUENTA_TIEMPO_HR12_EN
    // Midnight rollover from 23:59:59.98.
    setMode = 1'b1; setSel = 2'b01;
    applyStimulus(1'b1, 22, 2);
    setSel = 2'b00;
    applyStimulus(1'b1, 59, 2);
    checkOutput("preset2359", {csBcd, segBcd, minBcd, hrBcd}, 32'h00005923);
    setMode = 1'b0;
    applyStimulus(1'b0, 5998, 2);
    checkOutput("preload", {csBcd, segBcd, minBcd, hrBcd}, 32'h98595923);
    applyStimulus(1'b0, 1, 2);
    checkOutput("lastCs", {csBcd, segBcd, minBcd, hrBcd}, 32'h99595923);
    @(posedge clk); pulseCnt = 0;
    applyStimulus(1'b0, 1, 2);
    checkOutput("midnight", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000000);
    checkOutput("midnightPulses", pulseCnt, 1);
`else
    // Noon and 12->01 transitions with AM/PM.
    setMode = 1'b1; setSel = 2'b01;
    applyStimulus(1'b1, 10, 2);
    setSel = 2'b00;
    applyStimulus(1'b1, 59, 2);
    setMode = 1'b0;
    applyStimulus(1'b0, 5999, 2);
    checkOutput("preNoon", {csBcd, segBcd, minBcd, hrBcd}, 32'h99595911);
    checkOutput("preNoonPm", {31'b0, pmOut}, 32'h0);
    applyStimulus(1'b0, 1, 2);
    checkOutput("noon", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000012);
    checkOutput("noonPm", {31'b0, pmOut}, 32'h1);
    setMode = 1'b1; setSel = 2'b00;
    applyStimulus(1'b1, 59, 2);
    setMode = 1'b0;
    applyStimulus(1'b0, 5999, 2);
    checkOutput("pre1pm", {csBcd, segBcd, minBcd, hrBcd}, 32'h99595912);
    applyStimulus(1'b0, 1, 2);
    checkOutput("onePm", {csBcd, segBcd, minBcd, hrBcd}, 32'h00000001);
    checkOutput("onePmPm", {31'b0, pmOut}, 32'h1);
`endif

    // Randomized mix of ticks, presses, selectors and mode changes.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      f100   = 1'($urandom_range(0, 1));
      inc    = 1'($urandom_range(0, 1));
      setSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) setMode = ~setMode;
    end
    setMode = 1'b0; f100 = 1'b0; inc = 1'b0;
    repeat (SYNC + 4) @(negedge clk);

    // Reset between clock edges while counting, released with f100 high.
    applyStimulus(1'b0, 37, 2);
    f100 = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("asyncRst", {csBcd, segBcd, minBcd, hrBcd}, {24'h0, HR_RST});
    checkOutput("asyncRstPulse", {31'b0, segPulse}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("noSpurious", {csBcd, segBcd, minBcd, hrBcd}, {24'h0, HR_RST});
    f100 = 1'b0;
    applyStimulus(1'b0, 3, 2);
    checkOutput("afterRst", {csBcd, segBcd, minBcd, hrBcd}, {8'h03, 16'h0, HR_RST});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cuenta_tiempo.md
CUENTA_TIEMPO -- requirements
Module: cuenta_tiempo

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on f100 and inc (legal 2..3).
REQ-002 clk  input  1  master clock; the only clock in the block.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 f100  input  1  100 Hz square wave from the frequency divider; asynchronous to clk.
REQ-005 set_mode  input  1  1 = time-set mode, 0 = run mode; synchronous to clk.
REQ-006 set_sel  input  2  field to set: 2'b00 = minutes, 2'b01 = hours, others = no field.
REQ-007 inc  input  1  push-button increment, asynchronous to clk, already debounced.
REQ-008 cs_bcd  output  8  centiseconds, 2-digit BCD, 00..99.
REQ-009 seg_bcd  output  8  seconds, 2-digit BCD, 00..59.
REQ-010 min_bcd  output  8  minutes, 2-digit BCD, 00..59.
REQ-011 hr_bcd  output  8  hours, 2-digit BCD; range per REQ-030/031.
REQ-012 seg_pulse  output  1  one-clk strobe on each seconds increment.

Function
REQ-013 f100 and inc SHALL each pass through a SYNC_STAGES-flop synchronizer followed by a rising-edge detector, producing a one-clk tick or inc_p.
REQ-014 With SYNC_STAGES=2, tick SHALL assert on the 3rd clk rising edge after the f100 rising edge, and counters SHALL update on the following edge.
REQ-015 In run mode, each tick SHALL increment cs_bcd; 99 wraps to 00 with a carry to seconds.
REQ-016 In run mode, seconds SHALL wrap 59 to 00 with a carry to minutes, and minutes SHALL wrap 59 to 00 with a carry to hours.
REQ-017 In 24 h mode, hours SHALL wrap 23 to 00; 23:59:59.99 plus one tick SHALL give 00:00:00.00 in a single update.
REQ-018 seg_pulse SHALL be high exactly one clk, in the same cycle the seconds value updates; it SHALL never assert in set mode.
REQ-019 Each BCD digit SHALL stay in 0..9 at all times; no binary intermediate representation SHALL be visible on the outputs.
REQ-020 While set_mode=1, cs_bcd and seg_bcd SHALL be forced to 00 and ticks SHALL be ignored.
REQ-021 While set_mode=1, each inc_p SHALL increment the field selected by set_sel by 1, wrapping at its limit with no carry to the next field.
REQ-022 An inc_p with set_sel = 2'b10 or 2'b11, or with set_mode=0, SHALL be ignored.
REQ-023 When set_mode falls 1->0, counting SHALL resume from HH:MM:00.00, and the first tick SHALL take effect no earlier than the next cycle.
REQ-024 If tick and a set_mode rise occur in the same cycle, set mode SHALL win and the tick SHALL be discarded.
REQ-025 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 On rst=0, all counters, synchronizer flops and edge-detect flops SHALL clear asynchronously.
REQ-027 Reset values: cs_bcd = seg_bcd = min_bcd = 8'h00, seg_pulse = 0; hr_bcd = 8'h00 (24 h) or 8'h12 with pm=0 (12 h).
REQ-028 Reset assertion mid-count or mid-set SHALL take effect immediately, without waiting for a clk edge.
REQ-029 A stale f100 or inc level at reset release SHALL NOT generate a tick or inc_p: the edge detector SHALL start from the synchronized level.

Configuration
REQ-030 Without macro CUENTA_TIEMPO_HR12_EN, hours SHALL count 00..23 and the pm port SHALL NOT exist.
REQ-031 With CUENTA_TIEMPO_HR12_EN defined, the block SHALL have:
  - hours counting 12,01..11,12;
  - extra output pm (1 bit, 1 = PM);
  - pm toggling on the 11->12 transition in run mode, and on the 11->12 transition when hours are incremented in set mode.

Structure
REQ-032 A shared package SHALL hold the BCD limits (8'h99, 8'h59, 8'h23, 8'h12) and the set_sel encodings.
REQ-033 One sub-module, cnt_bcd2, SHALL implement the 2-digit BCD counter with enable, clear, parameterized max value, load-min value and carry_out; it is instantiated four times.

Verification
REQ-034 Reset release, then 100 f100 periods -> seg_bcd=8'h01, cs_bcd=8'h00, exactly one seg_pulse.
REQ-035 Preload 23:59:59.98 via set mode plus ticks, then 2 ticks -> 00:00:00.00 on the second tick, seg_pulse high once.
REQ-036 set_mode=1, set_sel=01, 25 inc pulses from 00 -> hr_bcd=8'h01, min_bcd unchanged, cs/seg held at 00.
REQ-037 set_sel=2'b11 with 5 inc pulses -> all outputs unchanged; inc in run mode -> ignored.
REQ-038 rst pulsed low mid-count, between clk edges -> outputs 00 (hr 12 with HR12) before the next clk edge, and no spurious tick after release.
REQ-039 With CUENTA_TIEMPO_HR12_EN, run through 11:59:59.99 -> 12:00:00.00 with pm 0->1; 12:59:59.99 -> 01:00:00.00 with pm unchanged.
